// File: rtl/ps2_mouse_packet_decoder_if.sv
// Byte stream from the PS/2 receiver into the mouse decoder, plus the
// decoded mouse state going back out.
//
// Handshake: byte_ready is a level from the receiver's clock domain; each
// rising edge presents one new byte on byte_data, which stays stable while
// byte_ready is high. There is no back-pressure, so the decoder must take
// every byte. pkt_valid, left_press, sync_err and timeout are single-cycle
// pulses. All other outputs are levels that hold between packets.
interface ps2_mouse_packet_decoder_if #(
  parameter int VEL_W = 10
);
  logic             byte_ready;
  logic [7:0]       byte_data;
  logic             pkt_valid;
  logic             btn_left;
  logic             btn_right;
  logic             btn_middle;
  logic             left_press;
  logic [VEL_W-1:0] vx;
  logic [VEL_W-1:0] vy;
  logic             dx;
  logic             dy;
  logic [3:0]       wheel;
  logic             sync_err;
  logic             timeout;
  logic [1:0]       dbg_state;

  modport master (
    output byte_ready, byte_data,
    input  pkt_valid, btn_left, btn_right, btn_middle, left_press,
    input  vx, vy, dx, dy, wheel, sync_err, timeout, dbg_state
  );

  modport slave (
    input  byte_ready, byte_data,
    output pkt_valid, btn_left, btn_right, btn_middle, left_press,
    output vx, vy, dx, dy, wheel, sync_err, timeout, dbg_state
  );
endinterface

// File: rtl/ps2_mouse_packet_decoder.sv
// PS/2 mouse packet decoder: assembles 3-byte (standard) or 4-byte (wheel)
// packets from the receiver byte stream, checks framing on byte0 bit3,
// resynchronises after an idle timeout, and produces sign-magnitude
// velocity, direction, buttons and wheel delta.
// VEL_W must equal the VEL_W of the connected interface instance.
module ps2_mouse_packet_decoder #(
  parameter int PKT_BYTES = 3,
  parameter int TIMEOUT   = 10000000,
  parameter int VSHIFT    = 1,
  parameter int VEL_W     = 10
) (
  input  logic                      clk,
  input  logic                      rstn,
  ps2_mouse_packet_decoder_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {B0, B1, B2, B3} state_t;
  state_t state;

  // sampler
  logic rdy_s1, rdy_s2, rdy_h;
  logic samp_live, samp_arm;
  logic accept;

  // packet bytes; only the bits the decode uses are kept
  logic [3:0] b0_hi;   // {Y ovf, X ovf, Y sign, X sign}
  logic [2:0] b0_btn;  // {middle, right, left}
  logic [7:0] b1, b2;
  logic [3:0] b3_lo;
  logic       done;

  logic [CNT_W-1:0] to_cnt;
  logic             to_fire;

  // registered outputs
  logic             pkt_valid_q, left_press_q, sync_err_q, timeout_q;
  logic             btn_l_q, btn_r_q, btn_m_q, dx_q, dy_q;
  logic [VEL_W-1:0] vx_q, vy_q;
  logic [3:0]       wheel_q;

  logic [8:0]       mag_x, mag_y;

  // A byte counts only after the sampler has seen byte_ready low once out of
  // reset, so a level left high across reset is not taken as a new byte.
  assign accept  = rdy_s2 & ~rdy_h & samp_arm;
  assign to_fire = (to_cnt == CNT_LAST) & ~accept;

  function automatic logic [8:0] magnitude(input logic sgn, input logic [7:0] d,
                                           input logic ovf);
    logic [8:0] v;
    v = {sgn, d};
    if (ovf) return 9'd255;
    return sgn ? (~v + 9'd1) : v;
  endfunction

  assign mag_x = magnitude(b0_hi[0], b1, b0_hi[2]);
  assign mag_y = magnitude(b0_hi[1], b2, b0_hi[3]);

  // Synchronise byte_ready into clk, keep a history flop for edge detect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_s1    <= 1'b0;
      rdy_s2    <= 1'b0;
      rdy_h     <= 1'b0;
      samp_live <= 1'b0;
      samp_arm  <= 1'b0;
    end else begin
      rdy_s1    <= bus.byte_ready;
      rdy_s2    <= rdy_s1;
      rdy_h     <= rdy_s2;
      samp_live <= 1'b1;
      if (samp_live && !rdy_s1) samp_arm <= 1'b1;
    end
  end

  // Idle counter: cleared by each byte, saturates one below TIMEOUT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt <= '0;
    end else if (accept) begin
      to_cnt <= '0;
    end else if (to_cnt != CNT_MAX) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Packet framing FSM; stores bytes and flags the final one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= B0;
      b0_hi      <= '0;
      b0_btn     <= '0;
      b1         <= '0;
      b2         <= '0;
      b3_lo      <= '0;
      done       <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      done       <= 1'b0;
      sync_err_q <= 1'b0;
      if (to_fire) begin
        state <= B0;
      end else if (accept) begin
        case (state)
          B0: begin
            if (bus.byte_data[3]) begin
              b0_hi  <= bus.byte_data[7:4];
              b0_btn <= bus.byte_data[2:0];
              state  <= B1;
            end else begin
              sync_err_q <= 1'b1;
            end
          end
          B1: begin
            b1    <= bus.byte_data;
            state <= B2;
          end
          B2: begin
            b2 <= bus.byte_data;
            if (PKT_BYTES == 4) begin
              state <= B3;
            end else begin
              state <= B0;
              done  <= 1'b1;
            end
          end
          default: begin
            b3_lo <= bus.byte_data[3:0];
            state <= B0;
            done  <= 1'b1;
          end
        endcase
      end
    end
  end

  // Output registers: load on a completed packet, clear velocity on timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_valid_q  <= 1'b0;
      left_press_q <= 1'b0;
      timeout_q    <= 1'b0;
      btn_l_q      <= 1'b0;
      btn_r_q      <= 1'b0;
      btn_m_q      <= 1'b0;
      dx_q         <= 1'b0;
      dy_q         <= 1'b0;
      vx_q         <= '0;
      vy_q         <= '0;
      wheel_q      <= '0;
    end else begin
      pkt_valid_q  <= done;
      left_press_q <= done & b0_btn[0] & ~btn_l_q;
      timeout_q    <= to_fire;
      if (done) begin
        btn_l_q <= b0_btn[0];
        btn_r_q <= b0_btn[1];
        btn_m_q <= b0_btn[2];
        dx_q    <= ~b0_hi[0];
        dy_q    <= ~b0_hi[1];
        vx_q    <= VEL_W'(mag_x >> VSHIFT);
        vy_q    <= VEL_W'(mag_y >> VSHIFT);
        wheel_q <= (PKT_BYTES == 4) ? b3_lo : 4'd0;
      end else if (to_fire) begin
        vx_q <= '0;
        vy_q <= '0;
      end
    end
  end

  assign bus.pkt_valid  = pkt_valid_q;
  assign bus.left_press = left_press_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.timeout    = timeout_q;
  assign bus.btn_left   = btn_l_q;
  assign bus.btn_right  = btn_r_q;
  assign bus.btn_middle = btn_m_q;
  assign bus.dx         = dx_q;
  assign bus.dy         = dy_q;
  assign bus.vx         = vx_q;
  assign bus.vy         = vy_q;
  assign bus.wheel      = wheel_q;
  assign bus.dbg_state  = state;
endmodule
